life_grid_engine: RTL and testbench

//   Parametrised Game-of-Life generation engine. Replaces the fixed 8x8 array with a ROWS x COLS grid.
//   The grid has a selectable edge mode (dead border or toroidal) and a row-sweep next-generation FSM

---
 rtl/life_grid_if.sv | 34 +++
 rtl/life_grid_engine.sv | 142 ++++++++++++++
 tb/tb_life_grid_engine.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/life_grid_if.sv
// Controller/display-side bundle for life_grid_engine: step handshake, cell writes,
// registered row reads and the committed-grid status outputs.
interface life_grid_if #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int GEN_W = 16
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(ROWS * COLS + 1);

    logic            step;
    logic            busy;
    logic            done;
    logic            wr_en;
    logic [RW-1:0]   wr_row;
    logic [CW-1:0]   wr_col;
    logic            wr_val;
    logic [RW-1:0]   rd_row;
    logic [COLS-1:0] rd_data;
    logic [GEN_W-1:0] generation;
    logic [PW-1:0]   population;
    logic            stable;

    modport master (
        output step, wr_en, wr_row, wr_col, wr_val, rd_row,
        input  busy, done, rd_data, generation, population, stable
    );

    modport slave (
        input  step, wr_en, wr_row, wr_col, wr_val, rd_row,
        output busy, done, rd_data, generation, population, stable
    );
endinterface

// File: rtl/life_grid_engine.sv
// ROWS x COLS Game-of-Life engine: one row of the next generation is evaluated per cycle
// into a staging buffer, then committed in a single cycle.
//
// state  | meaning
// IDLE   | accepts cell writes and step requests
// SWEEP  | evaluates row 'row' of the next generation into nxt
// COMMIT | copies nxt into cur, updates population/stable/generation
module life_grid_engine #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int WRAP  = 0,
    parameter int GEN_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    life_grid_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(ROWS * COLS + 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic WRAP_B = (WRAP != 0);

    typedef enum logic [1:0] {IDLE, SWEEP, COMMIT} state_t;

    state_t          state, state_nx;
    logic [COLS-1:0] cur [ROWS];
    logic [COLS-1:0] nxt [ROWS];
    logic [RW-1:0]   row;
    logic [PW-1:0]   pop_acc;
    logic            diff;
    logic            done_q;
    logic [COLS-1:0] rd_q;
    logic [GEN_W-1:0] gen_q;
    logic [PW-1:0]   pop_q;
    logic            stable_q;

    logic [COLS-1:0] row_up, row_mid, row_dn, row_new;
    logic [COLS+1:0] up_x, mid_x, dn_x;
    logic [3:0]      n;
    logic [PW-1:0]   row_pop;
    logic            wr_hit;

    assign bus.busy       = (state == SWEEP) || (state == COMMIT);
    assign bus.done       = done_q;
    assign bus.rd_data    = rd_q;
    assign bus.generation = gen_q;
    assign bus.population = pop_q;
    assign bus.stable     = stable_q;

    // A write only matters when it lands inside the grid and flips the cell.
    assign wr_hit = bus.wr_en
                 && (int'(bus.wr_row) < ROWS)
                 && (int'(bus.wr_col) < COLS)
                 && (cur[bus.wr_row][bus.wr_col] != bus.wr_val);

    always_comb begin
        row_mid = cur[row];
        if (row == '0)
            row_up = WRAP_B ? cur[LAST_ROW] : '0;
        else
            row_up = cur[row - 1'b1];
        if (row == LAST_ROW)
            row_dn = WRAP_B ? cur[0] : '0;
        else
            row_dn = cur[row + 1'b1];
    end

    // Ghost columns: bit 0 stands for column -1, bit COLS+1 for column COLS.
    always_comb begin
        up_x    = {WRAP_B & row_up[0],  row_up,  WRAP_B & row_up[COLS-1]};
        mid_x   = {WRAP_B & row_mid[0], row_mid, WRAP_B & row_mid[COLS-1]};
        dn_x    = {WRAP_B & row_dn[0],  row_dn,  WRAP_B & row_dn[COLS-1]};
        n       = '0;
        row_new = '0;
        row_pop = '0;
        for (int c = 0; c < COLS; c++) begin
            n = 4'(up_x[c]) + 4'(up_x[c+1]) + 4'(up_x[c+2])
              + 4'(mid_x[c]) + 4'(mid_x[c+2])
              + 4'(dn_x[c]) + 4'(dn_x[c+1]) + 4'(dn_x[c+2]);
            row_new[c] = (n == 4'd3) || (mid_x[c+1] && (n == 4'd2));
            row_pop    = row_pop + PW'(row_new[c]);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.step) state_nx = SWEEP;
            SWEEP:   if (row == LAST_ROW) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            row      <= '0;
            pop_acc  <= '0;
            diff     <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= '0;
            gen_q    <= '0;
            pop_q    <= '0;
            stable_q <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                cur[r] <= '0;
                nxt[r] <= '0;
            end
        end else begin
            state  <= state_nx;
            done_q <= (state == COMMIT);
            rd_q   <= (int'(bus.rd_row) < ROWS) ? cur[bus.rd_row] : '0;
            case (state)
                IDLE: begin
                    row     <= '0;
                    pop_acc <= '0;
                    diff    <= 1'b0;
                    if (wr_hit) begin
                        cur[bus.wr_row][bus.wr_col] <= bus.wr_val;
                        pop_q    <= bus.wr_val ? pop_q + PW'(1) : pop_q - PW'(1);
                        stable_q <= 1'b0;
                    end
                end
                SWEEP: begin
                    nxt[row] <= row_new;
                    pop_acc  <= pop_acc + row_pop;
                    diff     <= diff | (|(row_new ^ row_mid));
                    row      <= row + 1'b1;
                end
                COMMIT: begin
                    for (int r = 0; r < ROWS; r++)
                        cur[r] <= nxt[r];
                    pop_q    <= pop_acc;
                    stable_q <= ~diff;
                    gen_q    <= gen_q + GEN_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_life_grid_engine.sv
// Bench for life_grid_engine: a 5x5 dead-border engine and an 8x8 toroidal engine,
// each checked against a neighbour-counting reference model.
module tb_life_grid_engine;
    logic clk = 1'b0;
    logic rst5 = 1'b1;
    logic rst8 = 1'b1;
    int total = 0;
    int bad = 0;

    life_grid_if #(.ROWS(5), .COLS(5), .GEN_W(3))  b5();
    life_grid_if #(.ROWS(8), .COLS(8), .GEN_W(16)) b8();

    life_grid_engine #(.ROWS(5), .COLS(5), .WRAP(0), .GEN_W(3))
        u5 (.clk(clk), .reset(rst5), .bus(b5));
    life_grid_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(16))
        u8 (.clk(clk), .reset(rst8), .bus(b8));

    always #5 clk = ~clk;

    // reference model
    bit g [2][8][8];
    int R [2] = '{5, 8};
    int C [2] = '{5, 8};
    int W [2] = '{0, 1};
    int GW [2] = '{3, 16};
    int gen_m [2];
    bit st_m [2];

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int d, bit st, bit we, int r, int c, bit v);
        if (d == 0) begin
            b5.step = st; b5.wr_en = we; b5.wr_row = 3'(r); b5.wr_col = 3'(c); b5.wr_val = v;
        end else begin
            b8.step = st; b8.wr_en = we; b8.wr_row = 3'(r); b8.wr_col = 3'(c); b8.wr_val = v;
        end
    endtask

    function automatic logic get_busy(int d);   return (d == 0) ? b5.busy : b8.busy;     endfunction
    function automatic logic get_done(int d);   return (d == 0) ? b5.done : b8.done;     endfunction
    function automatic logic get_stable(int d); return (d == 0) ? b5.stable : b8.stable; endfunction
    function automatic logic [15:0] get_gen(int d);
        return (d == 0) ? 16'(b5.generation) : b8.generation;
    endfunction
    function automatic logic [7:0] get_pop(int d);
        return (d == 0) ? 8'(b5.population) : 8'(b8.population);
    endfunction
    function automatic logic [7:0] get_rd(int d);
        return (d == 0) ? 8'(b5.rd_data) : b8.rd_data;
    endfunction

    function automatic int model_pop(int d);
        int p = 0;
        for (int r = 0; r < R[d]; r++)
            for (int c = 0; c < C[d]; c++)
                p += int'(g[d][r][c]);
        return p;
    endfunction

    function automatic logic [7:0] model_row(int d, int r);
        logic [7:0] v = '0;
        for (int c = 0; c < C[d]; c++) v[c] = g[d][r][c];
        return v;
    endfunction

    function automatic int exp_gen(int d);
        return gen_m[d] % (1 << GW[d]);
    endfunction

    task automatic model_reset(int d);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                g[d][r][c] = 1'b0;
        gen_m[d] = 0;
        st_m[d]  = 1'b0;
    endtask

    task automatic model_write(int d, int r, int c, bit v);
        if (r < R[d] && c < C[d] && g[d][r][c] != v) begin
            g[d][r][c] = v;
            st_m[d] = 1'b0;
        end
    endtask

    task automatic model_step(int d);
        bit nx [8][8];
        bit changed = 1'b0;
        for (int r = 0; r < R[d]; r++)
            for (int c = 0; c < C[d]; c++) begin
                int cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (W[d] != 0) begin
                            rr = (rr + R[d]) % R[d];
                            cc = (cc + C[d]) % C[d];
                        end else if (rr < 0 || rr >= R[d] || cc < 0 || cc >= C[d]) begin
                            continue;
                        end
                        cnt += int'(g[d][rr][cc]);
                    end
                nx[r][c] = (cnt == 3) || (g[d][r][c] && cnt == 2);
            end
        for (int r = 0; r < R[d]; r++)
            for (int c = 0; c < C[d]; c++) begin
                if (nx[r][c] != g[d][r][c]) changed = 1'b1;
                g[d][r][c] = nx[r][c];
            end
        st_m[d] = ~changed;
        gen_m[d]++;
    endtask

    task automatic reset_dut(int d);
        if (d == 0) rst5 = 1'b1; else rst8 = 1'b1;
        tick();
        tick();
        if (d == 0) rst5 = 1'b0; else rst8 = 1'b0;
        model_reset(d);
        tick();
    endtask

    task automatic write_cell(int d, int r, int c, bit v);
        drive(d, 0, 1, r, c, v);
        tick();
        drive(d, 0, 0, 0, 0, 0);
        model_write(d, r, c, v);
    endtask

    task automatic read_row(int d, int r, output logic [7:0] v);
        if (d == 0) b5.rd_row = 3'(r); else b8.rd_row = 3'(r);
        tick();
        v = get_rd(d);
    endtask

    task automatic check_grid(int d, string tag);
        logic [7:0] v;
        for (int r = 0; r < R[d]; r++) begin
            read_row(d, r, v);
            chk($sformatf("%s_row%0d", tag, r), v, model_row(d, r));
        end
    endtask

    // Pulse step (optionally with a same-edge write) and wait for done with a cycle budget.
    task automatic do_step(int d, bit we, int r, int c, bit v, string tag);
        int lat = 0;
        if (we) model_write(d, r, c, v);
        drive(d, 1, we, r, c, v);
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            tick();
            if (k == 1) begin
                drive(d, 0, 0, 0, 0, 0);
                chk({tag, "_busy"}, get_busy(d), 1);
            end
            if (get_done(d)) lat = k;
        end
        chk({tag, "_lat"}, lat, R[d] + 2);
        model_step(d);
        chk({tag, "_gen"}, get_gen(d), exp_gen(d));
        chk({tag, "_pop"}, get_pop(d), model_pop(d));
        chk({tag, "_stable"}, get_stable(d), st_m[d]);
        chk({tag, "_idle"}, get_busy(d), 0);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] init_rows [8];
        int n;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        b5.rd_row = '0;
        b8.rd_row = '0;
        model_reset(0);
        model_reset(1);
        tick();
        tick();
        rst5 = 1'b0;
        rst8 = 1'b0;
        tick();

        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", get_busy(d), 0);
            chk("rst_done", get_done(d), 0);
            chk("rst_gen", get_gen(d), 0);
            chk("rst_pop", get_pop(d), 0);
            chk("rst_stable", get_stable(d), 0);
        end
        check_grid(0, "rst5");

        // blinker on 5x5 dead border, plus duplicate and out-of-range writes
        write_cell(0, 2, 1, 1);
        write_cell(0, 2, 2, 1);
        write_cell(0, 2, 3, 1);
        chk("blk_pop_w", get_pop(0), 3);
        write_cell(0, 2, 2, 1);
        write_cell(0, 5, 1, 1);
        write_cell(0, 1, 6, 1);
        write_cell(0, 7, 7, 1);
        chk("dup_oob_pop", get_pop(0), 3);
        read_row(0, 2, v);
        chk("blk_row2_pre", v, 8'b0000_1110);
        b5.rd_row = 3'd2;
        drive(0, 1, 0, 0, 0, 0);
        n = 0;
        for (int k = 1; k <= 40 && n == 0; k++) begin
            tick();
            if (k == 1) drive(0, 0, 0, 0, 0, 0);
            if (k == 4) chk("sweep_old_row", get_rd(0), 8'b0000_1110);
            if (get_done(0)) n = k;
        end
        chk("blk_lat", n, 7);
        model_step(0);
        chk("blk_gen", get_gen(0), 1);
        chk("blk_pop", get_pop(0), 3);
        chk("blk_stable", get_stable(0), 0);
        tick();
        chk("blk_row2_new", get_rd(0), 8'b0000_0100);
        check_grid(0, "blk");

        // step held high across done runs exactly as many generations as dones seen
        drive(0, 1, 0, 0, 0, 0);
        n = 0;
        for (int k = 1; k <= 40 && n < 2; k++) begin
            tick();
            if (get_done(0)) begin
                n++;
                if (n == 2) drive(0, 0, 0, 0, 0, 0);
            end
        end
        chk("held_dones", n, 2);
        model_step(0);
        model_step(0);
        n = 0;
        repeat (12) begin
            tick();
            if (get_done(0)) n++;
        end
        chk("held_extra_done", n, 0);
        chk("held_gen", get_gen(0), exp_gen(0));
        check_grid(0, "held");

        // 2x2 block still life; 8 steps wrap the 3-bit generation counter
        reset_dut(0);
        write_cell(0, 0, 0, 1);
        write_cell(0, 0, 1, 1);
        write_cell(0, 1, 0, 1);
        write_cell(0, 1, 1, 1);
        do_step(0, 0, 0, 0, 0, "block");
        chk("block_stable1", get_stable(0), 1);
        chk("block_pop4", get_pop(0), 4);
        check_grid(0, "block");
        for (int i = 0; i < 7; i++) do_step(0, 0, 0, 0, 0, "block_n");
        chk("gen_wrap", get_gen(0), 0);
        write_cell(0, 3, 3, 1);
        chk("write_clears_stable", get_stable(0), 0);

        // corner triple, dead border: all die
        reset_dut(0);
        write_cell(0, 0, 0, 1);
        write_cell(0, 0, 4, 1);
        write_cell(0, 4, 0, 1);
        do_step(0, 0, 0, 0, 0, "corner5");
        chk("corner5_pop0", get_pop(0), 0);

        // reset during sweep row 3
        reset_dut(0);
        write_cell(0, 2, 1, 1);
        write_cell(0, 2, 2, 1);
        write_cell(0, 2, 3, 1);
        b5.rd_row = 3'd2;
        drive(0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        chk("pre_rst_busy", get_busy(0), 1);
        rst5 = 1'b1;
        #1;
        chk("midrst_busy", get_busy(0), 0);
        chk("midrst_gen", get_gen(0), 0);
        chk("midrst_pop", get_pop(0), 0);
        chk("midrst_rd", get_rd(0), 0);
        tick();
        rst5 = 1'b0;
        model_reset(0);
        n = 0;
        repeat (12) begin
            tick();
            if (get_done(0)) n++;
        end
        chk("midrst_no_done", n, 0);
        check_grid(0, "midrst");

        // corner triple, toroidal: (7,7) is born
        write_cell(1, 0, 0, 1);
        write_cell(1, 0, 7, 1);
        write_cell(1, 7, 0, 1);
        do_step(1, 0, 0, 0, 0, "corner8");
        chk("corner8_pop4", get_pop(1), 4);
        read_row(1, 7, v);
        chk("corner8_row7", v, 8'b1000_0001);
        check_grid(1, "corner8");

        // glider returns home after 32 toroidal steps
        reset_dut(1);
        write_cell(1, 0, 1, 1);
        write_cell(1, 1, 2, 1);
        write_cell(1, 2, 0, 1);
        write_cell(1, 2, 1, 1);
        write_cell(1, 2, 2, 1);
        init_rows = '{8'h02, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 32; i++) begin
            do_step(1, 0, 0, 0, 0, "glider");
            chk("glider_pop5", get_pop(1), 5);
        end
        chk("glider_gen32", get_gen(1), 32);
        for (int r = 0; r < 8; r++) begin
            read_row(1, r, v);
            chk($sformatf("glider_home%0d", r), v, init_rows[r]);
        end

        // step and write during sweep are dropped
        drive(1, 1, 0, 0, 0, 0);
        n = 0;
        for (int k = 1; k <= 40 && n == 0; k++) begin
            tick();
            drive(1, 0, 0, 0, 0, 0);
            if (k == 3) drive(1, 1, 1, 5, 5, 1);
            if (get_done(1)) n = k;
        end
        chk("busy_ign_lat", n, 10);
        model_step(1);
        n = 0;
        repeat (14) begin
            tick();
            if (get_done(1)) n++;
        end
        chk("busy_ign_no_done", n, 0);
        chk("busy_ign_gen", get_gen(1), 33);
        chk("busy_ign_pop", get_pop(1), model_pop(1));
        check_grid(1, "busy_ign");

        // random soups on both engines; 8x8 also exercises write-with-step in IDLE
        for (int d = 0; d < 2; d++) begin
            reset_dut(d);
            for (int r = 0; r < R[d]; r++)
                for (int c = 0; c < C[d]; c++)
                    write_cell(d, r, c, 1'($urandom_range(0, 1)));
            chk("rnd_pop_fill", get_pop(d), model_pop(d));
            for (int i = 0; i < 4; i++) begin
                if (d == 1)
                    do_step(d, 1, $urandom_range(0, 7), $urandom_range(0, 7),
                            1'($urandom_range(0, 1)), "rnd_ws");
                else
                    do_step(d, 0, 0, 0, 0, "rnd");
                check_grid(d, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
